// File: rtl/sgbus_pkg.sv
// Shared sgbus helpers: index and counter width derivation for parametrised datapaths.
package sgbus_pkg;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // One extra bit so a counter can hold the value n itself, not just n-1
   function automatic int cnt_width(input int n);
      return idx_width(n) + 1;
   endfunction

endpackage

// File: rtl/elastic_slot.sv
// One elastic pipeline slot: valid bit plus payload register with async active-low reset.
module elastic_slot #(
   parameter type data_t = logic
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  load,
   input  logic  flush,
   input  logic  valid_in,
   input  data_t data_in,
   output logic  valid_q,
   output data_t data_q
);

   // Payload only captures real beats, so empty stages keep their last data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= valid_in;
         if (valid_in) begin
            data_q <= data_in;
         end
      end
   end

endmodule

// File: rtl/elastic_pipe.sv
// Stages-deep valid/ready register pipeline with bubble collapse, flush and occupancy count.
module elastic_pipe
   import sgbus_pkg::*;
#(
   parameter int  Stages = 4,
   parameter type data_t = logic
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  data_t                        din,
   output logic                         valid_o,
   input  logic                         ready_i,
   output data_t                        dout,
   output logic [cnt_width(Stages)-1:0] count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int CntW = cnt_width(Stages);

   logic [Stages-1:0] v;
   data_t             d [Stages];
   logic [Stages-1:0] rdy;
   logic              accept;
   logic              out_beat;
   logic [CntW-1:0]   count_q;

   // A stage may load if it or any stage downstream of it has room or is draining
   always_comb begin
      logic chain;
      chain = ready_i;
      rdy   = '0;
      for (int i = Stages - 1; i >= 0; i--) begin
         chain  = !v[i] | chain;
         rdy[i] = chain;
      end
   end

   for (genvar i = 0; i < Stages; i++) begin : g_stage
      logic  slot_vin;
      data_t slot_din;
      if (i == 0) begin : g_head
         assign slot_vin = valid_i;
         assign slot_din = din;
      end else begin : g_body
         assign slot_vin = v[i-1];
         assign slot_din = d[i-1];
      end

      elastic_slot #(.data_t(data_t)) u_slot (
         .clk      (clk),
         .reset_n  (reset_n),
         .load     (rdy[i]),
         .flush    (flush_i),
         .valid_in (slot_vin),
         .data_in  (slot_din),
         .valid_q  (v[i]),
         .data_q   (d[i])
      );
   end

   assign ready_o  = rdy[0] & !flush_i;
   assign valid_o  = v[Stages-1];
   assign dout     = d[Stages-1];
   assign accept   = valid_i & ready_o;
   assign out_beat = valid_o & ready_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (flush_i) begin
         count_q <= '0;
      end else if (accept && !out_beat) begin
         count_q <= count_q + CntW'(1);
      end else if (out_beat && !accept) begin
         count_q <= count_q - CntW'(1);
      end
   end

   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Stages));

   a_count_matches_valids: assert property (@(posedge clk) disable iff (!reset_n)
      count_q == CntW'($countones(v)));

   a_count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
      count_q <= CntW'(Stages));

   a_count_no_wrap: assert property (@(posedge clk) disable iff (!reset_n)
      !(empty_o && out_beat && !accept) && !(full_o && accept && !out_beat));

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe (4 stages, byte payload): queue-of-beats model plus directed scenarios.
module tb_elastic_pipe;

   localparam int S = 4;

   logic       clk;
   logic       reset_n;
   logic       flush_i;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] din;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] dout;
   logic [2:0] count_o;
   logic       empty_o;
   logic       full_o;

   elastic_pipe #(.Stages(S), .data_t(logic [7:0])) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .din     (din),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .dout    (dout),
      .count_o (count_o),
      .empty_o (empty_o),
      .full_o  (full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // Model: beats in order (oldest first) with their stage index 0..S-1
   logic [7:0] qd [$];
   int         qp [$];
   logic [7:0] top_d;
   logic [7:0] dut_out [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_valid();
      return (qp.size() > 0) && (qp[0] == S - 1);
   endfunction

   // Room exists anywhere in the pipe, or the output beat is leaving this cycle
   function automatic bit m_ready(input bit f, input bit r);
      return !f && ((qd.size() < S) || r);
   endfunction

   function automatic void m_clear();
      qd.delete();
      qp.delete();
      top_d = 8'h00;
   endfunction

   // Each beat advances one stage unless packed against the beats ahead of it
   function automatic void m_update(input bit f, input bit acc, input bit out, input logic [7:0] dv);
      if (out) begin
         void'(qd.pop_front());
         void'(qp.pop_front());
      end
      if (f) begin
         qd.delete();
         qp.delete();
      end else begin
         foreach (qp[k]) begin
            int lim;
            int np;
            lim = S - 1 - k;
            np  = (qp[k] + 1 < lim) ? qp[k] + 1 : lim;
            if (np == S - 1 && qp[k] != S - 1) top_d = qd[k];
            qp[k] = np;
         end
         if (acc) begin
            qd.push_back(dv);
            qp.push_back(0);
            if (S == 1) top_d = dv;
         end
      end
   endfunction

   task automatic compare_all();
      chk("ready_o", ready_o, m_ready(flush_i, ready_i));
      chk("valid_o", valid_o, m_valid());
      chk("count_o", count_o, qd.size());
      chk("empty_o", empty_o, qd.size() == 0);
      chk("full_o",  full_o,  qd.size() == S);
      chk("dout",    dout,    top_d);
   endtask

   task automatic step(input bit v, input logic [7:0] dv, input bit r, input bit f);
      bit acc;
      bit out;
      valid_i = v;
      din     = dv;
      ready_i = r;
      flush_i = f;
      #1;
      compare_all();
      acc = v && m_ready(f, r);
      out = m_valid() && r;
      if (valid_o && ready_i) dut_out.push_back(dout);
      @(posedge clk);
      edge_n++;
      m_update(f, acc, out, dv);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0);
   endtask

   initial begin
      int e0;
      int first_seen;

      reset_n = 1'b0;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      din     = 8'h00;
      m_clear();

      #2;
      chk("ready_in_reset", ready_o, 1'b1);
      flush_i = 1'b1;
      #1;
      chk("ready_in_reset_flush", ready_o, 1'b0);
      flush_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: idle after reset
      #1;
      chk("t1_valid", valid_o, 1'b0);
      chk("t1_count", count_o, 3'd0);
      chk("t1_empty", empty_o, 1'b1);
      chk("t1_ready", ready_o, 1'b1);
      chk("t1_dout",  dout,    8'h00);
      idle(2, 1'b1);

      // 2: back-to-back stream
      dut_out.delete();
      first_seen = -1;
      e0 = edge_n + 1;
      for (int i = 0; i < 12; i++) begin
         if (i < 8) step(1'b1, 8'(i + 1), 1'b1, 1'b0);
         else       step(1'b0, 8'h00, 1'b1, 1'b0);
         if (valid_o && first_seen < 0) first_seen = edge_n;
      end
      chk("t2_latency", first_seen - e0, 3);
      chk("t2_count", dut_out.size(), 8);
      for (int i = 0; i < 8 && i < dut_out.size(); i++) chk("t2_order", dut_out[i], 8'(i + 1));
      idle(2, 1'b1);

      // 3: stall until full, then one simultaneous out/in cycle
      dut_out.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      valid_i = 1'b1;
      din     = 8'hA4;
      #1;
      chk("t3_full", full_o, 1'b1);
      chk("t3_ready", ready_o, 1'b0);
      chk("t3_count", count_o, 3'd4);
      step(1'b1, 8'hA4, 1'b0, 1'b0);
      step(1'b1, 8'hA4, 1'b1, 1'b0);
      chk("t3_count_kept", count_o, 3'd4);
      chk("t3_first_out", (dut_out.size() > 0) ? dut_out[0] : 8'h00, 8'hA0);
      chk("t3_next_dout", dout, 8'hA1);
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      idle(6, 1'b1);
      chk("t3_total_out", dut_out.size(), 6);
      for (int i = 0; i < 6 && i < dut_out.size(); i++) chk("t3_order", dut_out[i], 8'hA0 + 8'(i));

      // 4: bubble collapse under stall
      step(1'b1, 8'h11, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("t4_count", count_o, 3'd2);
      chk("t4_ready", ready_o, 1'b1);
      chk("t4_valid", valid_o, 1'b1);
      chk("t4_dout", dout, 8'h11);
      idle(6, 1'b1);

      // 5: flush with a beat offered
      dut_out.delete();
      for (int i = 0; i < 3; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
      chk("t5_count_pre", count_o, 3'd3);
      valid_i = 1'b1;
      din     = 8'hFF;
      flush_i = 1'b1;
      #1;
      chk("t5_ready_flush", ready_o, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("t5_count_post", count_o, 3'd0);
      chk("t5_valid_post", valid_o, 1'b0);
      idle(6, 1'b1);
      chk("t5_nothing_out", dut_out.size(), 0);

      // 6: async reset between edges
      step(1'b1, 8'h41, 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      chk("t6_count_pre", count_o, 3'd2);
      valid_i = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_valid_rst", valid_o, 1'b0);
      chk("t6_count_rst", count_o, 3'd0);
      m_clear();
      @(negedge clk);
      reset_n = 1'b1;
      dut_out.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 8'h51 + 8'(i), 1'b1, 1'b0);
      idle(6, 1'b1);
      chk("t6_fresh_count", dut_out.size(), 4);
      for (int i = 0; i < 4 && i < dut_out.size(); i++) chk("t6_fresh_order", dut_out[i], 8'h51 + 8'(i));

      // Randomised traffic with varying backpressure and occasional flush
      for (int blk = 0; blk < 15; blk++) begin
         int rp;
         rp = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(99, 0) < 70,
                 8'($urandom),
                 $urandom_range(99, 0) < rp,
                 $urandom_range(99, 0) < 3);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
